scroll_strip: RTL and testbench
===============================

// Module: scroll_strip
// PURPOSE
//  Generalised N-segment horizontal scroller for the ground and parallax layers.
//  N_SEG equal-width segments tile a ring of N_SEG*SEG_WIDTH pixels and scroll
//  left by a fixed-point step on each frame-update pulse.
//  A segment leaving the left edge is re-queued behind the last one and given a
//  new random variant.
//  Sits between the game controller (update/start/crash/speed) and the sprite renderer.
// PARAMETERS
//  N_SEG          2    number of segments (>=2)
//  SEG_WIDTH      640  segment width, screen pixels
//  SCALE_LOG2     10   fractional bits of game position (scale 1024)
//  SPEED_W        15   width of speed input (unsigned, scaled px/update)
//  PARALLAX_SHIFT 0    step = speed >> PARALLAX_SHIFT (0..7)
//  VAR_BITS       1    variant index width (1..11)
//  derived: XPOS_W = $clog2(N_SEG*SEG_WIDTH)+2; GPOS_W = XPOS_W+SCALE_LOG2
// PORTS
//  clk        in   1               system clock
//  rst        in   1               synchronous, active-high reset
//  update     in   1               frame-update pulse
//  speed      in   SPEED_W         scaled scroll speed, unsigned
//  start      in   1               start / restart game
//  crash      in   1               freeze strip
//  rng_data   in   11              random source
//  x_pos      out  XPOS_W x N_SEG  signed left-edge pixel of each segment
//  variant    out  VAR_BITS x N_SEG  sprite variant of each segment
//  wrapped    out  N_SEG           1-cycle pulse: segment i re-queued this update
//  ready      out  1               1 = update will be accepted this cycle
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous and active-high.
//  Reset: state=WAITING; gpos[i]=i*SEG_WIDTH<<SCALE_LOG2; x_pos[i]=i*SEG_WIDTH;
//   variant=0; wrapped=0; ready=0.
//  rst mid-operation: overrides everything; reset values appear after that edge.
//  States:
//   WAITING  -start->  RUNNING
//   RUNNING  -update-> UPDATING
//   UPDATING ->        RUNNING (always, 1 cycle)
//   CRASHED  -start->  RUNNING, positions/variants re-initialised to reset values
//  crash in any state -> CRASHED, with priority over start and update the same
//   cycle; no movement occurs on that cycle.
//  ready = (state==RUNNING).
//  update while not RUNNING is dropped, not queued. Max one step per 2 cycles.
//  Step: applied on the edge that enters UPDATING.
//   step = speed >> PARALLAX_SHIFT, zero-extended to GPOS_W.
//   n = gpos[i] - step.
//   If n <= -(SEG_WIDTH<<SCALE_LOG2): n += N_SEG*SEG_WIDTH<<SCALE_LOG2,
//    wrapped[i]=1, variant[i] = rng_data[VAR_BITS-1:0] rotated left by i
//    (within VAR_BITS).
//   gpos[i]<=n; x_pos[i] <= n >>> SCALE_LOG2 (arithmetic; floor, -512 -> -1).
//  Latency: x_pos/variant/wrapped valid the cycle after update is sampled.
//   wrapped clears on the following edge.
//  Several segments may wrap on the same update; each gets its own rotated variant.
//  speed=0: update still passes through UPDATING; no movement, no wrap.
//  All segments are computed in parallel; no inter-segment dependency in one step.
// TESTING (defaults unless stated)
//  1 rst -> x_pos={0,640}, ready=0.
//    start -> ready=1 next cycle; update while WAITING -> no change.
//  2 speed=6144, one update -> x_pos={-6,634}, ready=0 for 1 cycle.
//    update held during UPDATING -> ignored.
//  3 preload gpos0=-636*1024, speed=4096, rng_data=11'h001 ->
//    x_pos0=640, variant0=1, wrapped=2'b01 for exactly 1 cycle.
//  4 crash and update same cycle -> x_pos unchanged, ready=0, later updates ignored;
//    start -> x_pos={0,640}, ready=1.
//  5 N_SEG=3, PARALLAX_SHIFT=2, speed=4096 -> x_pos={-1,639,1279};
//    speed=512 from reset -> x_pos0=-1 (floor).
//  6 rst asserted the cycle an update is sampled -> reset values, state WAITING,
//    no wrapped pulse.

Source files
------------

// File: rtl/scroll_strip_if.sv
// Control/status bundle between the game controller and a scroll_strip.
// The controller drives the master side; the strip is the slave.
interface scroll_strip_if #(
  parameter int N_SEG     = 2,
  parameter int SEG_WIDTH = 640,
  parameter int SPEED_W   = 15,
  parameter int VAR_BITS  = 1
);
  localparam int XPOS_W = $clog2(N_SEG * SEG_WIDTH) + 2;

  logic                               update;
  logic [SPEED_W-1:0]                 speed;
  logic                               start;
  logic                               crash;
  logic [10:0]                        rng_data;
  logic [N_SEG-1:0][XPOS_W-1:0]       x_pos;
  logic [N_SEG-1:0][VAR_BITS-1:0]     variant;
  logic [N_SEG-1:0]                   wrapped;
  logic                               ready;

  modport master (
    output update, speed, start, crash, rng_data,
    input  x_pos, variant, wrapped, ready
  );

  modport slave (
    input  update, speed, start, crash, rng_data,
    output x_pos, variant, wrapped, ready
  );
endinterface

// File: rtl/scroll_strip.sv
// N-segment ring scroller: segments step left on each accepted update and
// re-enter behind the last segment with a fresh random variant.
//   state    | meaning
//   WAITING  | idle after reset, waiting for start
//   RUNNING  | accepting updates (ready=1)
//   UPDATING | one-cycle holdoff after a step
//   CRASHED  | frozen until start re-initialises the strip
module scroll_strip #(
  parameter int N_SEG          = 2,
  parameter int SEG_WIDTH      = 640,
  parameter int SCALE_LOG2     = 10,
  parameter int SPEED_W        = 15,
  parameter int PARALLAX_SHIFT = 0,
  parameter int VAR_BITS       = 1
) (
  input logic          clk,
  input logic          rst,
  scroll_strip_if.slave bus
);
  localparam int XPOS_W = $clog2(N_SEG * SEG_WIDTH) + 2;
  localparam int GPOS_W = XPOS_W + SCALE_LOG2;

  localparam logic [1:0] S_WAITING  = 2'd0;
  localparam logic [1:0] S_RUNNING  = 2'd1;
  localparam logic [1:0] S_UPDATING = 2'd2;
  localparam logic [1:0] S_CRASHED  = 2'd3;

  localparam logic signed [GPOS_W-1:0] SEG_G    = GPOS_W'(SEG_WIDTH << SCALE_LOG2);
  localparam logic signed [GPOS_W-1:0] RING_G   = GPOS_W'((N_SEG * SEG_WIDTH) << SCALE_LOG2);
  localparam logic signed [GPOS_W-1:0] WRAP_LIM = -SEG_G;

  function automatic logic signed [GPOS_W-1:0] init_gpos(input int i);
    return GPOS_W'((i * SEG_WIDTH) << SCALE_LOG2);
  endfunction

  function automatic logic [VAR_BITS-1:0] rotl(input logic [VAR_BITS-1:0] v, input int r);
    logic [2*VAR_BITS-1:0] d;
    d = {v, v} << (r % VAR_BITS);
    return d[2*VAR_BITS-1:VAR_BITS];
  endfunction

  logic [1:0]                     state;
  logic signed [GPOS_W-1:0]       gpos     [N_SEG];
  logic signed [GPOS_W-1:0]       n_gpos   [N_SEG];
  logic signed [GPOS_W-1:0]       next_gpos[N_SEG];
  logic [N_SEG-1:0]               wrap_n;
  logic [N_SEG-1:0][VAR_BITS-1:0] next_var;
  logic [N_SEG-1:0][VAR_BITS-1:0] variant_q;
  logic [N_SEG-1:0]               wrapped_q;
  logic [SPEED_W-1:0]             step_raw;
  logic signed [GPOS_W-1:0]       step;

  // only the low VAR_BITS of the random source are consumed
  logic unused_rng;
  assign unused_rng = ^bus.rng_data;

  assign step_raw = bus.speed >> PARALLAX_SHIFT;
  assign step     = GPOS_W'(step_raw);

  always_comb begin
    wrap_n   = '0;
    next_var = '0;
    for (int i = 0; i < N_SEG; i++) begin
      n_gpos[i]    = gpos[i] - step;
      wrap_n[i]    = (n_gpos[i] <= WRAP_LIM);
      next_gpos[i] = wrap_n[i] ? n_gpos[i] + RING_G : n_gpos[i];
      next_var[i]  = rotl(bus.rng_data[VAR_BITS-1:0], i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAITING;
      variant_q <= '0;
      wrapped_q <= '0;
      for (int i = 0; i < N_SEG; i++) gpos[i] <= init_gpos(i);
    end else begin
      wrapped_q <= '0;
      if (bus.crash) begin
        state <= S_CRASHED;
      end else begin
        case (state)
          S_WAITING: if (bus.start) state <= S_RUNNING;
          S_RUNNING: begin
            if (bus.update) begin
              state     <= S_UPDATING;
              wrapped_q <= wrap_n;
              for (int i = 0; i < N_SEG; i++) begin
                gpos[i] <= next_gpos[i];
                if (wrap_n[i]) variant_q[i] <= next_var[i];
              end
            end
          end
          S_UPDATING: state <= S_RUNNING;
          S_CRASHED: begin
            if (bus.start) begin
              state     <= S_RUNNING;
              variant_q <= '0;
              for (int i = 0; i < N_SEG; i++) gpos[i] <= init_gpos(i);
            end
          end
          default: state <= S_WAITING;
        endcase
      end
    end
  end

  // pixel position is the floor of the fixed-point position
  for (genvar g = 0; g < N_SEG; g++) begin : g_xpos
    assign bus.x_pos[g] = XPOS_W'(gpos[g] >>> SCALE_LOG2);
  end

  assign bus.variant = variant_q;
  assign bus.wrapped = wrapped_q;
  assign bus.ready   = (state == S_RUNNING);
endmodule

// File: tb/tb_scroll_strip.sv
// Scoreboard bench for scroll_strip: a 2-segment default strip and a
// 3-segment parallax strip share clock and reset.
module tb_scroll_strip;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  scroll_strip_if #(.N_SEG(2)) ia ();
  scroll_strip_if #(.N_SEG(3), .VAR_BITS(3)) ib ();

  scroll_strip #(.N_SEG(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  scroll_strip #(.N_SEG(3), .PARALLAX_SHIFT(2), .VAR_BITS(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {
    int    cyc;
    int    dut;
    string name;
    int    x0, x1, x2;
    int    vr, wr, rdy;
  } exp_t;

  exp_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input int d, input string nm, input int x0, input int x1,
                       input int vr, input int wr, input int rdy);
    q.push_back('{cyc + d, 0, nm, x0, x1, 0, vr, wr, rdy});
  endtask

  task automatic exp_b(input int d, input string nm, input int x0, input int x1, input int x2,
                       input int vr, input int wr, input int rdy);
    q.push_back('{cyc + d, 1, nm, x0, x1, x2, vr, wr, rdy});
  endtask

  // monitor: pops every expectation due this cycle and compares
  exp_t e;
  int ax0, ax1, ax2, avr, awr, ardy;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else begin
        if (e.dut == 0) begin
          ax0 = $signed(ia.x_pos[0]); ax1 = $signed(ia.x_pos[1]); ax2 = 0;
          avr = int'(ia.variant); awr = int'(ia.wrapped); ardy = int'(ia.ready);
        end else begin
          ax0 = $signed(ib.x_pos[0]); ax1 = $signed(ib.x_pos[1]); ax2 = $signed(ib.x_pos[2]);
          avr = int'(ib.variant); awr = int'(ib.wrapped); ardy = int'(ib.ready);
        end
        if (ax0 != e.x0 || ax1 != e.x1 || ax2 != e.x2 || avr != e.vr || awr != e.wr || ardy != e.rdy) begin
          n_bad++;
          $display("FAIL %s: got x=%0d,%0d,%0d var=%0d wr=%0d rdy=%0d ; want x=%0d,%0d,%0d var=%0d wr=%0d rdy=%0d",
                   e.name, ax0, ax1, ax2, avr, awr, ardy, e.x0, e.x1, e.x2, e.vr, e.wr, e.rdy);
        end
      end
    end
  end

  task automatic run_a(input int n);
    for (int k = 0; k < n; k++) begin
      ia.update = 1'b1; tick(); ia.update = 1'b0; tick();
    end
  endtask

  task automatic run_b(input int n);
    for (int k = 0; k < n; k++) begin
      ib.update = 1'b1; tick(); ib.update = 1'b0; tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (now cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ia.update = 0; ia.speed = '0; ia.start = 0; ia.crash = 0; ia.rng_data = '0;
    ib.update = 0; ib.speed = '0; ib.start = 0; ib.crash = 0; ib.rng_data = '0;
    tick(); tick();
    rst = 1'b0;
    exp_a(0, "a_reset", 0, 640, 0, 0, 0);
    exp_b(0, "b_reset", 0, 640, 1280, 0, 0, 0);

    // parallax strip: step = speed >> 2
    ib.start = 1; tick(); ib.start = 0;
    exp_b(0, "b_start", 0, 640, 1280, 0, 0, 1);
    ib.speed = 15'd4096; ib.update = 1;
    exp_b(1, "b_step", -1, 639, 1279, 0, 0, 0);
    tick(); ib.update = 0;
    exp_b(1, "b_step_rdy", -1, 639, 1279, 0, 0, 1);
    tick();

    rst = 1; tick(); rst = 0;
    exp_b(0, "b_rst", 0, 640, 1280, 0, 0, 0);
    exp_a(0, "a_rst", 0, 640, 0, 0, 0);
    ib.start = 1; tick(); ib.start = 0;
    ib.speed = 15'd512; ib.update = 1;
    exp_b(1, "b_floor", -1, 639, 1279, 0, 0, 0);
    tick(); ib.update = 0; tick();

    // main strip: update while WAITING is dropped
    ia.update = 1;
    exp_a(1, "a_upd_waiting", 0, 640, 0, 0, 0);
    tick(); ia.update = 0;
    ia.start = 1;
    exp_a(1, "a_start", 0, 640, 0, 0, 1);
    tick(); ia.start = 0;

    ia.speed = 15'd6144; ia.update = 1;
    exp_a(1, "a_step6", -6, 634, 0, 0, 0);
    tick(); ia.update = 0;
    exp_a(1, "a_step6_rdy", -6, 634, 0, 0, 1);
    tick();

    // update held across UPDATING gives a single step
    ia.update = 1;
    exp_a(1, "a_held_1", -12, 628, 0, 0, 0);
    tick();
    exp_a(1, "a_held_2", -12, 628, 0, 0, 1);
    tick(); ia.update = 0;

    for (int k = 1; k <= 104; k++) begin
      ia.update = 1;
      if (k % 26 == 0) exp_a(1, "a_run", -12 - 6 * k, 628 - 6 * k, 0, 0, 0);
      tick(); ia.update = 0; tick();
    end

    // segment 0 lands exactly on the wrap boundary
    ia.speed = 15'd4096; ia.rng_data = 11'h001; ia.update = 1;
    exp_a(1, "a_wrap", 640, 0, 1, 1, 0);
    tick(); ia.update = 0; ia.rng_data = '0;
    exp_a(1, "a_wrap_clr", 640, 0, 1, 0, 1);
    tick();

    ia.speed = '0; ia.update = 1;
    exp_a(1, "a_speed0", 640, 0, 1, 0, 0);
    tick(); ia.update = 0;
    exp_a(1, "a_speed0_rdy", 640, 0, 1, 0, 1);
    tick();

    // crash beats update, then beats start
    ia.speed = 15'd4096; ia.crash = 1; ia.update = 1;
    exp_a(1, "a_crash", 640, 0, 1, 0, 0);
    tick(); ia.crash = 0;
    exp_a(1, "a_crashed_upd", 640, 0, 1, 0, 0);
    tick(); ia.update = 0;
    ia.crash = 1; ia.start = 1;
    exp_a(1, "a_crash_over_start", 640, 0, 1, 0, 0);
    tick(); ia.crash = 0;
    exp_a(1, "a_restart", 0, 640, 0, 0, 1);
    tick(); ia.start = 0;

    // reset on the cycle an update is sampled
    ia.speed = 15'd6144; ia.update = 1;
    exp_a(1, "a_pre_rst", -6, 634, 0, 0, 0);
    tick(); ia.update = 0; tick();
    rst = 1; ia.update = 1;
    exp_a(1, "a_rst_upd", 0, 640, 0, 0, 0);
    tick(); rst = 0;
    exp_a(1, "a_after_rst_upd", 0, 640, 0, 0, 0);
    tick(); ia.update = 0;

    // parallax strip wraps: step 4 px, rotated variants
    ib.start = 1; tick(); ib.start = 0;
    ib.speed = 15'd16384;
    run_b(159);
    ib.rng_data = 11'h003; ib.update = 1;
    exp_b(1, "b_wrap0", 1280, 0, 640, 3, 1, 0);
    tick(); ib.update = 0; ib.rng_data = '0;
    exp_b(1, "b_wrap0_clr", 1280, 0, 640, 3, 0, 1);
    tick();
    run_b(159);
    ib.rng_data = 11'h003; ib.update = 1;
    exp_b(1, "b_wrap1", 640, 1280, 0, 51, 2, 0);
    tick(); ib.update = 0; ib.rng_data = '0;
    exp_b(1, "b_wrap1_clr", 640, 1280, 0, 51, 0, 1);
    tick();

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      n_cmp += q.size();
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
